hv_power_sequencer: RTL

Sequences the RPSC supply chain (FAN, Cathode, Grid1, Anode, Grid2, Driver Amp) on and off in fixed order, one stage at a time. Each stage is gated by its permit and must be confirmed by its ACT feedback. Any interlock fault drops every HV stage at once, and the fan runs on for a fixed time. The block sits between the synchronised EP inputs (after inputFF) and the stage-enable outputs that drive the C10/C11 LA and EP relays.

---
 rtl/rpsc_seq_pkg.sv | 26 ++
 rtl/seq_timer.sv | 18 +
 rtl/hv_power_sequencer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/rpsc_seq_pkg.sv
// rpsc_seq_pkg: shared states, stage indices and helpers for the RPSC supply sequencer.
package rpsc_seq_pkg;
  localparam int NUM_STAGES = 6;
  localparam logic [2:0] STG_FAN = 3'd0;
  localparam logic [2:0] STG_CA = 3'd1;
  localparam logic [2:0] STG_G1 = 3'd2;
  localparam logic [2:0] STG_AN = 3'd3;
  localparam logic [2:0] STG_G2 = 3'd4;
  localparam logic [2:0] STG_DRAMP = 3'd5;
  typedef enum logic [2:0] {
    S_IDLE, S_RAMP_UP, S_CA_WARM, S_RUN, S_RAMP_DOWN, S_FAN_RUNON, S_FAULT
  } state_t;
  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    return m > d ? m : d;
  endfunction
  // Highest enabled HV stage (1..5); 0 means no HV stage is on.
  function automatic logic [2:0] hi_stage(input logic [NUM_STAGES-1:0] m);
    logic [2:0] h;
    h = 3'd0;
    for (int i = 1; i < NUM_STAGES; i++) h = m[i] ? 3'(i) : h;
    return h;
  endfunction
endpackage

// File: rtl/seq_timer.sv
// seq_timer: loadable down-counter that saturates at zero; done while the count is zero.
module seq_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else if (load) cnt <= value;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  end
  assign done = cnt == '0;
endmodule

// File: rtl/hv_power_sequencer.sv
// hv_power_sequencer: orders the RPSC supply stages on/off with permit, ACT and interlock handling.
module hv_power_sequencer
  import rpsc_seq_pkg::*;
#(
  parameter int CA_DELAY_CYCLES = 60,
  parameter int ACK_TIMEOUT = 100,
  parameter int DOWN_GAP = 5,
  parameter int FAN_OFF_DELAY = 120
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic                  i_stop,
  input  logic                  i_fault,
  input  logic                  i_clear,
  input  logic [NUM_STAGES-1:0] i_perm,
  input  logic [NUM_STAGES-1:0] i_ack,
  output logic [NUM_STAGES-1:0] o_on,
  output logic [2:0]            o_state,
  output logic [2:0]            o_idx,
  output logic                  o_ready,
  output logic                  o_timeout
);
  localparam int TW = $clog2(max4(CA_DELAY_CYCLES, ACK_TIMEOUT, DOWN_GAP, FAN_OFF_DELAY)) + 1;
  // Loaded with N-1 so that expiry is acted on exactly N edges after the load edge.
  localparam logic [TW-1:0] T_CA = TW'(CA_DELAY_CYCLES - 1);
  localparam logic [TW-1:0] T_ACK = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] T_GAP = TW'(DOWN_GAP - 1);
  localparam logic [TW-1:0] T_FAN = TW'(FAN_OFF_DELAY - 1);
  state_t state, state_n;
  logic [NUM_STAGES-1:0] on_n, rest;
  logic [2:0] idx_n, drop_h;
  logic ready_n, to_n, ld, tmr_done, go_fault, do_drop, acked, perm_loss, last;
  logic [TW-1:0] ld_val;
  seq_timer #(.W(TW)) u_timer (
    .clk(clk), .reset(reset), .load(ld), .value(ld_val), .done(tmr_done)
  );
  assign o_state = state;
  assign acked = o_on[o_idx] & i_ack[o_idx];
  assign perm_loss = |(o_on & ~i_perm);
  assign drop_h = hi_stage(o_on);
  assign rest = o_on & ~(NUM_STAGES'(1) << drop_h);
  assign last = hi_stage(rest) == 3'd0;
  always_comb begin
    state_n = state;
    idx_n = o_idx;
    on_n = o_on;
    ready_n = 1'b0;
    to_n = o_timeout;
    ld = 1'b0;
    ld_val = '0;
    go_fault = 1'b0;
    do_drop = 1'b0;
    if (state != S_FAULT && (i_fault || (state != S_IDLE && perm_loss))) go_fault = 1'b1;
    else begin
      case (state)
        S_IDLE: if (i_start && !i_stop) begin
          state_n = S_RAMP_UP;
          idx_n = STG_FAN;
          ld = 1'b1;
          ld_val = T_ACK;
        end
        S_RAMP_UP: begin
          if (tmr_done && !acked) begin
            go_fault = 1'b1;
            to_n = 1'b1;
          end else if (i_stop) do_drop = 1'b1;
          else if (acked) begin
            state_n = o_idx == STG_CA ? S_CA_WARM : o_idx == STG_DRAMP ? S_RUN : S_RAMP_UP;
            idx_n = (o_idx == STG_CA || o_idx == STG_DRAMP) ? o_idx : o_idx + 3'd1;
            ready_n = o_idx == STG_DRAMP;
            ld = o_idx != STG_DRAMP;
            ld_val = o_idx == STG_CA ? T_CA : T_ACK;
          end else if (i_perm[o_idx]) on_n[o_idx] = 1'b1;
        end
        S_CA_WARM: begin
          if (i_stop) do_drop = 1'b1;
          else if (tmr_done) begin
            state_n = S_RAMP_UP;
            idx_n = STG_G1;
            ld = 1'b1;
            ld_val = T_ACK;
          end
        end
        S_RUN: begin
          do_drop = i_stop;
          ready_n = !i_stop;
        end
        S_RAMP_DOWN: do_drop = tmr_done;
        S_FAN_RUNON: if (!o_on[STG_FAN] || tmr_done) begin
          on_n[STG_FAN] = 1'b0;
          state_n = S_IDLE;
        end
        S_FAULT: begin
          on_n[STG_FAN] = o_on[STG_FAN] && !tmr_done;
          if (i_clear && !i_fault && tmr_done) begin
            state_n = S_IDLE;
            to_n = 1'b0;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
    if (go_fault) begin
      state_n = S_FAULT;
      on_n = o_on & NUM_STAGES'(1);
      ready_n = 1'b0;
      ld = 1'b1;
      ld_val = T_FAN;
    end
    // Each drop clears the highest enabled stage; unused stages are skipped outright.
    if (do_drop) begin
      on_n = drop_h == 3'd0 ? o_on : rest;
      idx_n = drop_h == 3'd0 ? o_idx : drop_h;
      state_n = (drop_h == 3'd0 || last) ? S_FAN_RUNON : S_RAMP_DOWN;
      ld = 1'b1;
      ld_val = (drop_h == 3'd0 || last) ? T_FAN : T_GAP;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      o_idx <= '0;
      o_on <= '0;
      o_ready <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      state <= state_n;
      o_idx <= idx_n;
      o_on <= on_n;
      o_ready <= ready_n;
      o_timeout <= to_n;
    end
  end
endmodule
